// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared width codes, fault codes and FSM states for the data-memory LSU
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;
    localparam logic [1:0] FAULT_FUNCT3   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - word-wide storage with byte write enables and a registered read port
module dmem_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              re_i,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    // Contents start at zero and are deliberately outside any reset domain.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit: fault decode, lane steering and response handshake
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [1:0]  resp_fault_code
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    lsu_state_e  state_q, state_d;
    logic        accept;
    logic [31:0] offset;
    logic        illegal, misaligned, out_of_range;
    logic [1:0]  fault_code;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [3:0]  bank_we;
    logic        bank_re;
    logic [31:0] bank_rdata;

    logic        ld_q, fault_q;
    logic [1:0]  code_q, off_q;
    logic [2:0]  funct3_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_ready  = (state_q == ST_IDLE) || resp_ready;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP);
    // BASE_ADDR is size-aligned, so offset[1:0] equals the byte lane of req_addr.
    assign offset     = req_addr - BASE_ADDR;

    always_comb begin
        illegal = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                         : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = |offset[31:ADDR_W+2];
        if (illegal)           fault_code = FAULT_FUNCT3;
        else if (misaligned)   fault_code = FAULT_MISALIGN;
        else if (out_of_range) fault_code = FAULT_RANGE;
        else                   fault_code = FAULT_NONE;
    end

    always_comb begin
        st_be   = 4'b1111;
        st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << offset[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = offset[1] ? 4'b1100 : 4'b0011;
                st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = req_wdata;
            end
        endcase
    end

    // rst gating keeps a store that lands on the reset edge from touching memory.
    assign bank_we = (accept && req_we && (fault_code == FAULT_NONE) && !rst) ? st_be : 4'b0000;
    assign bank_re = accept && !req_we && (fault_code == FAULT_NONE);

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_bank (
        .clk    (clk),
        .re_i   (bank_re),
        .we_i   (bank_we),
        .addr_i (offset[ADDR_W+1:2]),
        .wdata_i(st_data),
        .rdata_o(bank_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: if (resp_ready && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ld_q     <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FAULT_NONE;
            funct3_q <= F3_B;
            off_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ld_q     <= !req_we && (fault_code == FAULT_NONE);
                fault_q  <= (fault_code != FAULT_NONE);
                code_q   <= fault_code;
                funct3_q <= req_funct3;
                off_q    <= offset[1:0];
            end
        end
    end

    // The bank output only moves on a new load, so the extended result holds under backpressure.
    always_comb begin
        ld_byte    = bank_rdata[{off_q, 3'b000} +: 8];
        ld_half    = off_q[1] ? bank_rdata[31:16] : bank_rdata[15:0];
        resp_rdata = bank_rdata;
        case (funct3_q)
            F3_B:    resp_rdata = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   resp_rdata = {24'h0, ld_byte};
            F3_H:    resp_rdata = {{16{ld_half[15]}}, ld_half};
            F3_HU:   resp_rdata = {16'h0, ld_half};
            default: resp_rdata = bank_rdata;
        endcase
        if (!ld_q) resp_rdata = 32'h0;
    end

    assign resp_fault      = fault_q;
    assign resp_fault_code = code_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized and directed bench for dmem_lsu against a byte-array model
module tb_dmem_lsu;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem_b [4*DEPTH];

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [35:0] exp;
    } dir_t;

    always #5 clk = ~clk;

    dmem_lsu #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .resp_fault_code(resp_fault_code)
    );

    // Byte-addressed reference: returns {valid, fault, code, rdata} and applies stores.
    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [35:0] exp);
        int          size;
        logic [31:0] off;
        logic [31:0] v;
        logic [1:0]  code;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = addr - BASE;
        v    = 32'h0;
        if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7}))
            code = 2'd3;
        else if ((addr % 32'(size)) != 32'd0)
            code = 2'd1;
        else if ((off / 32'd4) >= 32'(DEPTH))
            code = 2'd2;
        else begin
            code = 2'd0;
            for (int b = 0; b < size; b++) begin
                if (we) mem_b[off + 32'(b)] = wdata[8*b +: 8];
                else    v = v | (32'(mem_b[off + 32'(b)]) << (8*b));
            end
            if (!we && !f3[2] && size < 4 && v[8*size-1])
                v = v | (32'hFFFF_FFFF << (8*size));
        end
        exp = {1'b1, code != 2'd0, code, v};
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [35:0] obs);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        obs = {resp_valid, resp_fault, resp_fault_code, resp_rdata};
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({resp_valid, resp_fault, resp_fault_code, resp_rdata} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {resp_valid, resp_fault, resp_fault_code, resp_rdata}, 36'h0);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        dir_t        tbl[$];
        logic [35:0] obs, mexp;
        tbl.push_back({1'b1, 3'd2, 32'h10,   32'h11223344, 36'h8_0000_0000});
        tbl.push_back({1'b0, 3'd2, 32'h10,   32'h0,        36'h8_1122_3344});
        tbl.push_back({1'b1, 3'd0, 32'h13,   32'h123456AB, 36'h8_0000_0000});
        tbl.push_back({1'b0, 3'd0, 32'h13,   32'h0,        36'h8_FFFF_FFAB});
        tbl.push_back({1'b0, 3'd4, 32'h13,   32'h0,        36'h8_0000_00AB});
        tbl.push_back({1'b0, 3'd2, 32'h10,   32'h0,        36'h8_AB22_3344});
        tbl.push_back({1'b0, 3'd1, 32'h12,   32'h0,        36'h8_FFFF_AB22});
        tbl.push_back({1'b0, 3'd1, 32'h11,   32'h0,        36'hD_0000_0000});
        tbl.push_back({1'b1, 3'd2, 32'h12,   32'hDEADBEEF, 36'hD_0000_0000});
        tbl.push_back({1'b0, 3'd2, 32'h10,   32'h0,        36'h8_AB22_3344});
        tbl.push_back({1'b0, 3'd2, 32'h1000, 32'h0,        36'hE_0000_0000});
        tbl.push_back({1'b0, 3'd3, 32'h10,   32'h0,        36'hF_0000_0000});
        tbl.push_back({1'b1, 3'd4, 32'h10,   32'hFFFFFFFF, 36'hF_0000_0000});
        tbl.push_back({1'b0, 3'd2, 32'h10,   32'h0,        36'h8_AB22_3344});
        tbl.push_back({1'b1, 3'd1, 32'h16,   32'h0000BEEF, 36'h8_0000_0000});
        tbl.push_back({1'b0, 3'd1, 32'h16,   32'h0,        36'h8_FFFF_BEEF});
        tbl.push_back({1'b0, 3'd5, 32'h16,   32'h0,        36'h8_0000_BEEF});
        tbl.push_back({1'b0, 3'd2, 32'hFFC,  32'h0,        36'h8_0000_0000});
        tbl.push_back({1'b1, 3'd2, 32'hFFC,  32'h89ABCDEF, 36'h8_0000_0000});
        tbl.push_back({1'b0, 3'd2, 32'hFFC,  32'h0,        36'h8_89AB_CDEF});
        tbl.push_back({1'b0, 3'd1, 32'h1001, 32'h0,        36'hD_0000_0000});
        tbl.push_back({1'b1, 3'd3, 32'h1001, 32'h0,        36'hF_0000_0000});
        tbl.push_back({1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,   36'hE_0000_0000});
        foreach (tbl[i]) begin
            model_op(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, mexp);
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, obs);
            tests_run++;
            if (obs !== tbl[i].exp) begin
                tests_failed++;
                $display("FAIL directed[%0d]: got %h expected %h", i, obs, tbl[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic [35:0] obs, exp;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          sel;
        for (int i = 0; i < 300; i++) begin
            we    = 1'($urandom_range(0, 1));
            f3    = 3'($urandom_range(0, 7));
            wdata = $urandom;
            sel   = int'($urandom_range(0, 9));
            if (sel < 6)      addr = 32'($urandom_range(0, 63));
            else if (sel < 8) addr = 32'(4*DEPTH - 8) + 32'($urandom_range(0, 15));
            else              addr = $urandom;
            model_op(we, f3, addr, wdata, exp);
            do_req(we, f3, addr, wdata, obs);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d] we=%b f3=%0d addr=%h: got %h expected %h",
                         i, we, f3, addr, obs, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp, exp2;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b1;
        model_op(1'b0, 3'd2, 32'h10, 32'h0, exp);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        // A store is offered while stalled; it must not be taken until the consumer frees up.
        req_we = 1'b1; req_wdata = 32'h5555AAAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if ({resp_valid, resp_fault, resp_fault_code, resp_rdata} !== exp) begin
                tests_failed++;
                $display("FAIL hold_resp[%0d]: got %h expected %h", k,
                         {resp_valid, resp_fault, resp_fault_code, resp_rdata}, exp);
            end
            tests_run++;
            if (req_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_req_ready[%0d]: got %b expected 0", k, req_ready);
            end
        end
        req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_req_ready: got %b expected 1", req_ready);
        end
        model_op(1'b0, 3'd2, 32'h10, 32'h0, exp2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({resp_valid, resp_fault, resp_fault_code, resp_rdata} !== exp2) begin
            tests_failed++;
            $display("FAIL release_resp: got %h expected %h",
                     {resp_valid, resp_fault, resp_fault_code, resp_rdata}, exp2);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] expq[$];
        logic [35:0] exp;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata;
        int          n = 60;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            resp_ready = 1'b1;
            if (i > 0) begin
                exp = expq.pop_front();
                tests_run++;
                if ({resp_valid, resp_fault, resp_fault_code, resp_rdata} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b[%0d]: got %h expected %h", i - 1,
                             {resp_valid, resp_fault, resp_fault_code, resp_rdata}, exp);
                end
            end
            if (i < n) begin
                we    = 1'($urandom_range(0, 1));
                f3    = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
                if (f3 == 3'd3) f3 = 3'd2;
                addr  = 32'($urandom_range(0, 15));
                if (f3[1:0] == 2'd1) addr[0] = 1'b0;
                if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
                wdata = $urandom;
                model_op(we, f3, addr, wdata, exp);
                expq.push_back(exp);
                req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_held();
        logic [35:0] obs, exp;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; resp_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (resp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_before_rst: got %b expected 1", resp_valid);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({resp_valid, resp_fault, resp_fault_code, resp_rdata} !== 36'h0) begin
            tests_failed++;
            $display("FAIL rst_discard: got %h expected %h",
                     {resp_valid, resp_fault, resp_fault_code, resp_rdata}, 36'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        // A store present on the edge where reset rises must be dropped.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; resp_ready = 1'b1;
        #4 rst = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_op(1'b0, 3'd2, 32'h10, 32'h0, exp);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, obs);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL mem_kept_after_rst: got %h expected %h", obs, exp);
        end
        model_op(1'b0, 3'd2, 32'h20, 32'h0, exp);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, obs);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL store_on_rst_edge: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) mem_b[i] = 8'h00;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, 1024: number of 32-bit words; SHALL be a power of two >= 4.
REQ-002 Parameter BASE_ADDR, 32'h0000_0000: byte address of word 0; SHALL be DEPTH_WORDS*4 aligned.
REQ-003 clk  in  1  clock; all state SHALL change on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request can be accepted this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (bits [7:0] for SB).
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  consumer accepts response.
REQ-013 resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and faults.
REQ-014 resp_fault  out  1  request was not performed.
REQ-015 resp_fault_code  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal funct3.

Function
REQ-016 Request accepted on a rising edge where req_valid && req_ready.
REQ-017 State machine: IDLE (no response held) and RESP (response held); IDLE->RESP on accept; RESP->IDLE on resp_ready without a new accept; RESP->RESP on resp_ready with a new accept.
REQ-018 req_ready SHALL be 1 in IDLE, and resp_ready in RESP (combinational pass-through); throughput one request per cycle.
REQ-019 Latency: resp_valid SHALL assert on the edge after acceptance.
REQ-020 While resp_valid && !resp_ready, resp_rdata/resp_fault/resp_fault_code SHALL hold stable.
REQ-021 Loads: word read at acceptance edge; byte/half selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended.
REQ-022 Stores: SB writes one byte lane at addr[1:0], SH two lanes at addr[1], SW all four; other lanes unchanged.
REQ-023 Fault check order: illegal funct3 (store with funct3 other than 000/001/010; load with 011/110/111), then misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0), then out of range ((addr-BASE_ADDR)>>2 >= DEPTH_WORDS, unsigned).
REQ-024 A faulting request SHALL write no byte, return resp_rdata 0, resp_fault 1 with the code per REQ-015.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the newly stored bytes.
REQ-026 Memory contents SHALL initialise to all zero at time zero.

Reset
REQ-027 During rst: state IDLE, resp_valid 0, resp_rdata 0, resp_fault 0, resp_fault_code 00.
REQ-028 Reset asserted with a response held SHALL discard that response; memory contents SHALL NOT be cleared.
REQ-029 A store accepted on the edge coinciding with rst assertion SHALL NOT be performed.

Structure
REQ-030 Package dmem_pkg SHALL hold funct3 width constants, fault code constants and the state enum.
REQ-031 Storage SHALL be a sub-module dmem_bank: DEPTH_WORDS x 32, four byte write enables, synchronous read port.
REQ-032 Lane steering, extension and fault decoding SHALL be in dmem_lsu; no read-modify-write cycle.

Verification
REQ-033 SW 0x11223344 @0x10, then LW @0x10 -> resp_rdata 0x11223344, resp_fault 0, one-cycle latency.
REQ-034 SB 0xAB @0x13, then LB @0x13 -> 0xFFFFFFAB; LBU @0x13 -> 0x000000AB; LW @0x10 -> 0xAB223344.
REQ-035 LH @0x11 -> fault 1, code 01, rdata 0; SW @0x12 -> code 01 and word @0x10 unchanged.
REQ-036 LW @BASE_ADDR+4*DEPTH_WORDS -> code 10; load with funct3 011 -> code 11; store with funct3 100 -> code 11.
REQ-037 Hold resp_ready 0 for 3 cycles after a load -> req_ready 0, response stable; release -> back-to-back requests accepted every cycle.
REQ-038 Assert rst while a response is held -> resp_valid 0 immediately; after release, previously stored data still readable.
